// File: rtl/slc3_pkg.sv
// Shared SLC-3 control definitions: FSM state encoding, opcodes and datapath mux encodings.
// Pause states exist only when ISDU_PAUSE_EN is defined.
package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_18,
    S_33,
    S_35,
    S_32,
    S_01,
    S_05,
    S_09,
    S_00,
    S_22,
    S_12,
    S_04,
    S_20,
    S_21,
    S_06,
    S_07,
    S_25,
    S_27,
    S_23,
    S_16
`ifdef ISDU_PAUSE_EN
    ,
    S_PAUSE1,
    S_PAUSE2
`endif
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  // States that stretch over MEM_WAIT cycles using the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/isdu.sv
// SLC-3 instruction sequencer/decoder unit: Moore FSM driving datapath load strobes, bus gates and muxes.
// Define ISDU_PAUSE_EN to enable the PAUSE instruction (opcode 1101) with its LED latch strobe.
module isdu
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DR,
  output logic       SR1MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;
  logic       last_wait;

  // IR_5 is decoded by the datapath, not here; Continue is idle when pausing is compiled out.
  logic unused_inputs;
  assign unused_inputs = ^{IR_5, Continue};

  assign last_wait = (wait_cnt == 3'(MEM_WAIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HALTED;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (is_mem_state(state) && !last_wait) wait_cnt <= wait_cnt + 3'd1;
      else                                   wait_cnt <= '0;
    end
  end

  // NOTE: every output and state_next gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALU_ADD;
    DR         = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    case (state)
      S_HALTED: if (Run) state_next = S_18;
      S_18: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        PCMUX      = PCMUX_INC;
        LD_PC      = 1'b1;
        state_next = S_33;
      end
      S_33, S_25: begin
        Mem_OE = 1'b1;
        LD_MDR = last_wait;
        if (last_wait) state_next = (state == S_33) ? S_35 : S_27;
      end
      S_35: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        state_next = S_32;
      end
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   state_next = S_01;
          OP_AND:   state_next = S_05;
          OP_NOT:   state_next = S_09;
          OP_BR:    state_next = S_00;
          OP_JMP:   state_next = S_12;
          OP_JSR:   state_next = S_04;
          OP_LDR:   state_next = S_06;
          OP_STR:   state_next = S_07;
`ifdef ISDU_PAUSE_EN
          OP_PAUSE: state_next = S_PAUSE1;
`endif
          default:  state_next = S_18;
        endcase
      end
      S_01, S_05, S_09: begin
        SR1MUX     = 1'b1;
        ALUK       = (state == S_01) ? ALU_ADD : (state == S_05) ? ALU_AND : ALU_NOT;
        GateALU    = 1'b1;
        DR         = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_next = S_18;
      end
      S_00: state_next = BEN ? S_22 : S_18;
      S_22: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_SEXT9;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        state_next = S_18;
      end
      S_12, S_21: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_ZERO;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        state_next = S_18;
      end
      S_04: begin
        GatePC     = 1'b1;
        DR         = 1'b0;
        LD_REG     = 1'b1;
        state_next = IR_11 ? S_20 : S_21;
      end
      S_20: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_SEXT11;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        state_next = S_18;
      end
      S_06, S_07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_SEXT6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_next = (state == S_06) ? S_25 : S_23;
      end
      S_27: begin
        GateMDR    = 1'b1;
        DR         = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_next = S_18;
      end
      S_23: begin
        SR1MUX     = 1'b0;
        ALUK       = ALU_PASSA;
        GateALU    = 1'b1;
        MIO_EN     = 1'b1;
        LD_MDR     = 1'b1;
        state_next = S_16;
      end
      S_16: begin
        Mem_WE = 1'b1;
        if (last_wait) state_next = S_18;
      end
`ifdef ISDU_PAUSE_EN
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_next = S_PAUSE2;
      end
      S_PAUSE2: if (!Continue) state_next = S_18;
`endif
      default: state_next = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// Self-checking bench for isdu: three instances (MEM_WAIT 1, 2, 3) share stimulus and are compared
// cycle by cycle against an instruction-level sequence model built from the control-unit rules.
module tb_isdu;

  localparam int NCYC = 40;
  localparam int NDUT = 3;

  typedef enum int {
    T_HALT, T_18, T_33, T_35, T_32, T_01, T_05, T_09, T_00, T_22, T_12,
    T_04, T_20, T_21, T_06, T_07, T_25, T_27, T_23, T_16, T_P1, T_P2
  } step_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       dr, sr1mux, addr1mux, mio_en, mem_oe, mem_we;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       ir_5 = 1'b0;
  logic       ir_11 = 1'b0;
  logic       ben = 1'b0;
  ctl_t       obs [NDUT];

  int total = 0;
  int bad = 0;

  logic  run_s  [NCYC];
  logic  cont_s [NCYC];
  step_e exp_s  [NDUT][NCYC];
  logic  exp_l  [NDUT][NCYC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       dr, sr1mux, addr1mux, mio_en, mem_oe, mem_we;

    isdu #(.MEM_WAIT(g + 1)) u_dut (
      .clk(clk), .reset(reset), .Run(run), .Continue(cont), .Opcode(opcode),
      .IR_5(ir_5), .IR_11(ir_11), .BEN(ben),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
      .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
      .DR(dr), .SR1MUX(sr1mux), .ADDR1MUX(addr1mux), .MIO_EN(mio_en),
      .Mem_OE(mem_oe), .Mem_WE(mem_we)
    );

    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                     gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, aluk,
                     dr, sr1mux, addr1mux, mio_en, mem_oe, mem_we};
  end

  // Control word each step must present; anything not named stays 0.
  function automatic ctl_t expect_ctl(input step_e s, input logic last);
    ctl_t e;
    e = '0;
    case (s)
      T_18: begin e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; e.pcmux = 2'b00; end
      T_33, T_25: begin e.mem_oe = 1; e.ld_mdr = last; end
      T_35: begin e.gate_mdr = 1; e.ld_ir = 1; end
      T_32: e.ld_ben = 1;
      T_01, T_05, T_09: begin
        e.sr1mux = 1; e.gate_alu = 1; e.dr = 1; e.ld_reg = 1; e.ld_cc = 1;
        e.aluk = (s == T_01) ? 2'b00 : (s == T_05) ? 2'b01 : 2'b10;
      end
      T_22: begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; end
      T_12, T_21: begin e.sr1mux = 1; e.addr1mux = 1; e.pcmux = 2'b10; e.ld_pc = 1; end
      T_04: begin e.gate_pc = 1; e.ld_reg = 1; end
      T_20: begin e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1; end
      T_06, T_07: begin
        e.sr1mux = 1; e.addr1mux = 1; e.addr2mux = 2'b01; e.gate_marmux = 1; e.ld_mar = 1;
      end
      T_27: begin e.gate_mdr = 1; e.dr = 1; e.ld_reg = 1; e.ld_cc = 1; end
      T_23: begin e.aluk = 2'b11; e.gate_alu = 1; e.mio_en = 1; e.ld_mdr = 1; end
      T_16: e.mem_we = 1;
      T_P1: e.ld_led = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic put(input int d, inout int c, input step_e s, input logic l);
    if (c < NCYC) begin
      exp_s[d][c] = s;
      exp_l[d][c] = l;
    end
    c++;
  endtask

  // Expand the run/continue streams into the per-cycle step sequence for one MEM_WAIT value.
  task automatic build_expect(input int d, input logic [3:0] op, input logic b, input logic i11);
    int c;
    int k;
    int mw;
    mw = d + 1;
    c = 0;
    while (c < NCYC && !run_s[c]) put(d, c, T_HALT, 1'b0);
    put(d, c, T_HALT, 1'b0);
    while (c < NCYC) begin
      put(d, c, T_18, 1'b0);
      for (int w = 0; w < mw; w++) put(d, c, T_33, w == mw - 1);
      put(d, c, T_35, 1'b0);
      put(d, c, T_32, 1'b0);
      case (op)
        4'b0001: put(d, c, T_01, 1'b0);
        4'b0101: put(d, c, T_05, 1'b0);
        4'b1001: put(d, c, T_09, 1'b0);
        4'b0000: begin
          put(d, c, T_00, 1'b0);
          if (b) put(d, c, T_22, 1'b0);
        end
        4'b1100: put(d, c, T_12, 1'b0);
        4'b0100: begin
          put(d, c, T_04, 1'b0);
          put(d, c, i11 ? T_20 : T_21, 1'b0);
        end
        4'b0110: begin
          put(d, c, T_06, 1'b0);
          for (int w = 0; w < mw; w++) put(d, c, T_25, w == mw - 1);
          put(d, c, T_27, 1'b0);
        end
        4'b0111: begin
          put(d, c, T_07, 1'b0);
          put(d, c, T_23, 1'b0);
          for (int w = 0; w < mw; w++) put(d, c, T_16, w == mw - 1);
        end
`ifdef ISDU_PAUSE_EN
        4'b1101: begin
          while (c < NCYC) begin
            k = c;
            put(d, c, T_P1, 1'b0);
            if (cont_s[k]) break;
          end
          while (c < NCYC) begin
            k = c;
            put(d, c, T_P2, 1'b0);
            if (!cont_s[k]) break;
          end
        end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    cont  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_trial(input string tag, input logic [3:0] op, input logic b,
                           input logic i11, input logic i5);
    ctl_t e;
    do_reset();
    opcode = op;
    ben    = b;
    ir_11  = i11;
    ir_5   = i5;
    for (int d = 0; d < NDUT; d++) build_expect(d, op, b, i11);
    for (int c = 0; c < NCYC; c++) begin
      run  = run_s[c];
      cont = cont_s[c];
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        e = expect_ctl(exp_s[d][c], exp_l[d][c]);
        total++;
        if (obs[d] !== e) begin
          bad++;
          $display("FAIL %s mw=%0d cyc=%0d step=%s got=%h want=%h",
                   tag, d + 1, c, exp_s[d][c].name(), obs[d], e);
        end
        total++;
        if ($countones({obs[d].gate_pc, obs[d].gate_mdr, obs[d].gate_alu, obs[d].gate_marmux}) > 1) begin
          bad++;
          $display("FAIL %s_bus mw=%0d cyc=%0d gates got=%b want at most one",
                   tag, d + 1, c, {obs[d].gate_pc, obs[d].gate_mdr, obs[d].gate_alu, obs[d].gate_marmux});
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Run pulses once in cycle 0, then random noise; Continue random noise.
  task automatic noise_streams();
    for (int c = 0; c < NCYC; c++) begin
      run_s[c]  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cont_s[c] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    do_reset();
    cont = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if (obs[d] !== '0) begin
          bad++;
          $display("FAIL reset_idle mw=%0d cyc=%0d got=%h want=0", d + 1, c, obs[d]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    ctl_t e;
    do_reset();
    opcode = 4'b0001;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    e = '0;
    e.mem_oe = 1'b1;
    e.ld_mdr = 1'b1;
    total++;
    if (obs[1] !== e) begin
      bad++;
      $display("FAIL mid_wait_s33 got=%h want=%h", obs[1], e);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if (obs[d] !== '0) begin
          bad++;
          $display("FAIL mid_wait_reset mw=%0d cyc=%0d got=%h want=0", d + 1, c, obs[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    noise_streams();
    run_trial("add", 4'b0001, 1'b0, 1'b0, 1'b1);
    noise_streams();
    run_trial("and", 4'b0101, 1'b1, 1'b1, 1'b0);
    noise_streams();
    run_trial("not", 4'b1001, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_branch();
    noise_streams();
    run_trial("br_not_taken", 4'b0000, 1'b0, 1'b0, 1'b0);
    noise_streams();
    run_trial("br_taken", 4'b0000, 1'b1, 1'b0, 1'b0);
    noise_streams();
    run_trial("jmp", 4'b1100, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_jsr();
    noise_streams();
    run_trial("jsr", 4'b0100, 1'b0, 1'b1, 1'b0);
    noise_streams();
    run_trial("jsrr", 4'b0100, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_memory();
    noise_streams();
    run_trial("ldr", 4'b0110, 1'b0, 1'b0, 1'b0);
    noise_streams();
    run_trial("str", 4'b0111, 1'b1, 1'b1, 1'b1);
  endtask

  // Continue 0,0,1,1,0 lines up with PAUSE1 entry of the MEM_WAIT=2 instance (cycle 6).
  task automatic test_pause();
    noise_streams();
    for (int c = 0; c < 5; c++) cont_s[6 + c] = (c == 2 || c == 3);
    run_trial("pause", 4'b1101, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCYC; c++) begin
        run_s[c]  = ($urandom_range(0, 3) == 0);
        cont_s[c] = 1'($urandom_range(0, 1));
      end
      run_trial("random", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_alu();
    test_branch();
    test_jsr();
    test_memory();
    test_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isdu.md
ISDU -- requirements
Module: isdu

Interface
REQ-001 Parameter: MEM_WAIT, default 2, memory access cycles per read/write (legal 1..7).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Run  in  1  start fetching from HALTED; Continue  in  1  leave PAUSE state.
REQ-005 Opcode  in  4  IR[15:12]; IR_5  in  1  immediate select; IR_11  in  1  JSR/JSRR select; BEN  in  1  branch-enable from datapath.
REQ-006 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load strobes.
REQ-007 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle.
REQ-008 PCMUX  out  2  00 PC+1, 01 bus, 10 adder; ADDR2MUX  out  2  00 zero, 01 SEXT6, 10 SEXT9, 11 SEXT11; ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
REQ-009 DR, SR1MUX, ADDR1MUX, MIO_EN  out  1 each  DR 0=R7/1=IR[11:9]; SR1MUX 0=IR[11:9]/1=IR[8:6]; ADDR1MUX 0=PC/1=SR1; MIO_EN 0=memory/1=bus into MDR.
REQ-010 Mem_OE, Mem_WE  out  1 each  memory read/write enables, active-high.

Function
REQ-011 Moore FSM; all outputs decoded from state (and wait counter) only; unlisted outputs 0 in every state.
REQ-012 HALTED: idle; Run=1 -> S18, else stay.
REQ-013 S18: GatePC, LD_MAR, PCMUX=00, LD_PC -> S33.
REQ-014 S33: Mem_OE=1, MIO_EN=0 for MEM_WAIT cycles; LD_MDR on last cycle only -> S35.
REQ-015 S35: GateMDR, LD_IR -> S32.
REQ-016 S32: LD_BEN; decode Opcode: 0001 S01, 0101 S05, 1001 S09, 0000 S00, 1100 S12, 0100 S04, 0110 S06, 0111 S07, 1101 PAUSE; any other -> S18 (NOP).
REQ-017 S01/S05/S09: SR1MUX=1, ALUK=00/01/10, GateALU, DR=1, LD_REG, LD_CC -> S18.
REQ-018 S00: BEN=1 -> S22, else S18; S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
REQ-019 S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
REQ-020 S04: GatePC, DR=0, LD_REG; IR_11=1 -> S20 (ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC), else S21 (SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC); both -> S18.
REQ-021 S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR; S06 -> S25, S07 -> S23.
REQ-022 S25: as S33 -> S27; S27: GateMDR, DR=1, LD_REG, LD_CC -> S18.
REQ-023 S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=1, LD_MDR -> S16; S16: Mem_WE=1 for MEM_WAIT cycles -> S18.
REQ-024 Wait counter 3 bits, cleared on entry to any memory state, saturates never beyond MEM_WAIT-1; MEM_WAIT=1 gives single-cycle states.
REQ-025 Run has no effect outside HALTED; Continue has no effect outside PAUSE.

Reset
REQ-026 reset=1 forces HALTED and counter 0 on next edge, from any state including mid-memory-wait; all outputs 0 while in HALTED.

Configuration
REQ-027 Macro ISDU_PAUSE_EN defined: opcode 1101 -> PAUSE1 (LD_LED=1) holds while Continue=0, then PAUSE2 holds while Continue=1, then -> S18.
REQ-028 ISDU_PAUSE_EN undefined: opcode 1101 treated as NOP (S32 -> S18); LD_LED tied 0; PAUSE states absent.

Structure
REQ-029 Shared package slc3_pkg holds state enum, opcode constants, PCMUX/ADDR2MUX/ALUK encodings; datapath and isdu import it.
REQ-030 Single module, no sub-modules; state register and next-state/output logic separated.

Verification
REQ-031 reset mid-S33 (cycle 2 of 2) -> HALTED next edge, all outputs 0, Run=0 keeps HALTED.
REQ-032 Run=1, Opcode=0001, MEM_WAIT=2 -> S18,S33,S33,S35,S32,S01,S18; LD_MDR high only in second S33; LD_REG+LD_CC in S01.
REQ-033 Opcode=0000, BEN=0 -> S32,S00,S18 with LD_PC never high in S00; BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10.
REQ-034 Opcode=0111, MEM_WAIT=3 -> S07,S23,S16x3,S18; Mem_WE high exactly 3 cycles, ALUK=11 and MIO_EN=1 in S23.
REQ-035 Opcode=0100, IR_11=1 -> S04 (DR=0, GatePC, LD_REG), S20 (ADDR2MUX=11); IR_11=0 -> S21 (ADDR1MUX=1).
REQ-036 With ISDU_PAUSE_EN, Opcode=1101, Continue 0,0,1,1,0 -> PAUSE1,PAUSE1,PAUSE2,PAUSE2,S18; LD_LED high in PAUSE1; without macro -> S32,S18.
